// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: command codes, FSM states
// and small command-classification helpers.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic is_muldiv_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the MIPS HI/LO pair; mul/div take
// WIDTH+1 enabled cycles, MTHI/MTLO complete in one.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_e          state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               start;
    logic               last_step;
    logic               op_sgn;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     add_a, add_b;
    logic               add_cin;
    logic [WIDTH+1:0]   add_sum;
    logic [2*WIDTH-1:0] acc_step;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        if (is_signed && v[WIDTH-1])
            return $unsigned(-sv);
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    assign ready     = (state == IDLE);
    assign start     = op_valid && ready && is_muldiv_op(op);
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    assign op_sgn = is_signed_op(op);
    assign rs_neg = op_sgn && rs_val[WIDTH-1];
    assign rt_neg = op_sgn && rt_val[WIDTH-1];
    assign rs_mag = magnitude(rs_val, op_sgn);
    assign rt_mag = magnitude(rt_val, op_sgn);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (clk_enable)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_step) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared WIDTH+1 adder: multiply adds the multiplicand into the upper half when
    // the current multiplier bit is set; divide subtracts the divisor from the
    // partial remainder extended by the next dividend bit (carry-out = no borrow).
    always_comb begin
        if (is_div) begin
            add_a   = acc[2*WIDTH-1:WIDTH-1];
            add_b   = ~{1'b0, opb};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc[2*WIDTH-1:WIDTH]};
            add_b   = acc[0] ? {1'b0, opb} : '0;
            add_cin = 1'b0;
        end
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    always_comb begin
        if (!is_div)
            acc_step = {add_sum[WIDTH:0], acc[WIDTH-1:1]};
        else if (add_sum[WIDTH+1])
            acc_step = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (clk_enable) begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        case (op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                // Divide seeds the low half with the dividend; multiply
                                // seeds it with the multiplier and keeps the multiplicand.
                                acc    <= {{WIDTH{1'b0}}, is_div_op(op) ? rs_mag : rt_mag};
                                opb    <= is_div_op(op) ? rt_mag : rs_mag;
                                is_div <= is_div_op(op);
                                neg_q  <= rs_neg ^ rt_neg;
                                neg_r  <= is_div_op(op) && rs_neg;
                                cnt    <= '0;
                                busy   <= 1'b1;
                            end
                            MD_MTHI: hi <= rs_val;
                            MD_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    busy <= 1'b0;
                    if (is_div) begin
                        lo <= apply_sign(acc[WIDTH-1:0], neg_q);
                        hi <= apply_sign(acc[2*WIDTH-1:WIDTH], neg_r);
                    end else begin
                        {hi, lo} <= apply_sign_wide(acc, neg_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32 (cycle-level reference model plus directed
// cases) and WIDTH=8 (directed and random operations against the arithmetic model).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset32, ce32, ov32;
    logic [2:0]  op32;
    logic [31:0] rs32, rt32, hi32, lo32;
    logic        ready32, busy32, done32;

    logic        reset8, ce8, ov8;
    logic [2:0]  op8;
    logic [7:0]  rs8, rt8, hi8, lo8;
    logic        ready8, busy8, done8;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    logic        m_busy, m_done;
    int          m_left;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset32), .clk_enable(ce32), .op_valid(ov32), .op(op32),
        .rs_val(rs32), .rt_val(rt32), .ready(ready32), .busy(busy32), .done(done32),
        .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .clk_enable(ce8), .op_valid(ov8), .op(op8),
        .rs_val(rs8), .rt_val(rt8), .ready(ready8), .busy(busy8), .done(done8),
        .hi(hi8), .lo(lo8)
    );

    // Arithmetic reference for a w-bit unit: returns {hi, lo} in the low w bits of each half.
    function automatic logic [63:0] ref_fn(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        logic [63:0] mask, ua, ub, up;
        longint      sa, sb, q, r;
        logic [31:0] rh, rl;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'b0, a} & mask;
        ub = {32'b0, b} & mask;
        sa = ua[w-1] ? longint'(ua) - longint'(mask) - 64'sd1 : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - longint'(mask) - 64'sd1 : longint'(ub);
        rh = '0;
        rl = '0;
        case (o)
            MD_MULT, MD_MULTU: begin
                if (o == MD_MULT) up = sa * sb;
                else              up = ua * ub;
                rl = 32'(up & mask);
                rh = 32'((up >> w) & mask);
            end
            MD_DIV: begin
                if (sb == 0) begin
                    rl = (sa >= 0) ? 32'(mask) : 32'd1;
                    rh = 32'(ua);
                end else if (sb == -1 && sa == -(64'sd1 <<< (w - 1))) begin
                    rl = 32'(ua);
                    rh = '0;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    rl = 32'($unsigned(q) & mask);
                    rh = 32'($unsigned(r) & mask);
                end
            end
            default: begin
                if (ub == 0) begin
                    rl = 32'(mask);
                    rh = 32'(ua);
                end else begin
                    rl = 32'(ua / ub);
                    rh = 32'(ua % ub);
                end
            end
        endcase
        return {rh, rl};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    // Transaction-level model of the 32-bit unit: a command in idle either writes
    // HI/LO at once or yields its result 33 enabled cycles later.
    always @(posedge clk) begin
        if (reset32) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else if (ce32) begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi <= m_res[63:32]; m_lo <= m_res[31:0];
                    m_done <= 1'b1; m_busy <= 1'b0;
                end
            end else if (ov32) begin
                if (op32 <= 3'd3) begin
                    m_res <= ref_fn(op32, rs32, rt32, 32);
                    m_left <= 33;
                    m_busy <= 1'b1;
                end else if (op32 == 3'd4) begin
                    m_hi <= rs32;
                end else if (op32 == 3'd5) begin
                    m_lo <= rs32;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_hi32",    64'(hi32),    64'(m_hi));
            chk("cyc_lo32",    64'(lo32),    64'(m_lo));
            chk("cyc_busy32",  64'(busy32),  64'(m_busy));
            chk("cyc_done32",  64'(done32),  64'(m_done));
            chk("cyc_ready32", 64'(ready32), 64'(!m_busy));
        end
    end

    task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_n,
                         input string name, input int stall_at, input int stall_len);
        int n;
        ov32 = 1'b1; op32 = o; rs32 = a; rt32 = b;
        cyc(1);
        ov32 = 1'b0;
        n = 0;
        while (!done32 && n < 200) begin
            ce32 = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
            cyc(1);
            n++;
        end
        ce32 = 1'b1;
        chk({name, "_cycles"}, 64'(n), 64'(exp_n));
        chk({name, "_hi"}, 64'(hi32), 64'(exp_hi));
        chk({name, "_lo"}, 64'(lo32), 64'(exp_lo));
        cyc(1);
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_hi, input logic [7:0] exp_lo, input string name);
        int n;
        ov8 = 1'b1; op8 = o; rs8 = a; rt8 = b;
        cyc(1);
        ov8 = 1'b0;
        n = 0;
        while (!done8 && n < 100) begin
            chk({name, "_busy"}, 64'(busy8), 64'(1));
            cyc(1);
            n++;
        end
        chk({name, "_cycles"}, 64'(n), 64'(9));
        chk({name, "_hi"}, 64'(hi8), 64'(exp_hi));
        chk({name, "_lo"}, 64'(lo8), 64'(exp_lo));
        cyc(1);
        chk({name, "_done_once"}, 64'(done8), 64'(0));
    endtask

    initial begin
        logic [63:0] e;
        int n;
        reset32 = 1'b1; ce32 = 1'b1; ov32 = 1'b0; op32 = '0; rs32 = '0; rt32 = '0;
        reset8  = 1'b1; ce8  = 1'b1; ov8  = 1'b0; op8  = '0; rs8  = '0; rt8  = '0;
        cyc(2);
        reset32 = 1'b0;
        chk_en  = 1'b1;
        chk("rst_hi",    64'(hi32),    64'(0));
        chk("rst_lo",    64'(lo32),    64'(0));
        chk("rst_busy",  64'(busy32),  64'(0));
        chk("rst_done",  64'(done32),  64'(0));
        chk("rst_ready", 64'(ready32), 64'(1));

        run32(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, "multu_max", -1, 0);
        run32(MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, "mult_m3x5", -1, 0);
        run32(MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         33, "mult_m1m1", -1, 0);
        run32(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_m7d2",  -1, 0);
        run32(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, "div_ovf",   -1, 0);
        run32(MD_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 33, "divu_zero", -1, 0);
        run32(MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'd1,         33, "div_zero_neg", -1, 0);
        run32(MD_DIVU,  32'd1000,      32'd7,         32'd6,         32'd142,       38, "divu_stall", 10, 5);

        ov32 = 1'b1; op32 = MD_MTHI; rs32 = 32'h1234;
        cyc(1);
        ov32 = 1'b0;
        chk("mthi_hi",   64'(hi32),   64'(32'h1234));
        chk("mthi_busy", 64'(busy32), 64'(0));
        cyc(1);
        chk("mthi_nodone", 64'(done32), 64'(0));

        ov32 = 1'b1; op32 = MD_MULT; rs32 = 32'd6; rt32 = 32'd7;
        cyc(1);
        op32 = MD_MTLO; rs32 = 32'hDEAD;
        cyc(3);
        ov32 = 1'b0;
        n = 0;
        while (!done32 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("mtlo_busy_wait", 64'(n < 200), 64'(1));
        chk("mtlo_busy_hi", 64'(hi32), 64'(0));
        chk("mtlo_busy_lo", 64'(lo32), 64'(42));
        cyc(1);

        ov32 = 1'b1; op32 = MD_MULTU; rs32 = 32'hFFFF_FFFF; rt32 = 32'h1234_5678;
        cyc(1);
        ov32 = 1'b0;
        cyc(10);
        reset32 = 1'b1;
        cyc(1);
        reset32 = 1'b0;
        chk("abort_hi",    64'(hi32),    64'(0));
        chk("abort_lo",    64'(lo32),    64'(0));
        chk("abort_busy",  64'(busy32),  64'(0));
        chk("abort_done",  64'(done32),  64'(0));
        chk("abort_ready", 64'(ready32), 64'(1));
        cyc(40);
        chk("abort_no_result", 64'({hi32, lo32}), 64'(0));

        for (int i = 0; i < 3000; i++) begin
            ov32    = ($urandom_range(0, 2) == 0);
            op32    = 3'($urandom_range(0, 7));
            rs32    = pick32();
            rt32    = pick32();
            ce32    = ($urandom_range(0, 9) != 0);
            reset32 = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        reset32 = 1'b0; ce32 = 1'b1; ov32 = 1'b0;
        cyc(40);

        reset8 = 1'b0;
        chk("rst8_ready", 64'(ready8), 64'(1));
        chk("rst8_busy",  64'(busy8),  64'(0));
        run8(MD_DIVU, 8'd200, 8'd7,  8'd4,   8'd28,  "divu8_200_7");
        run8(MD_MULT, 8'hFD,  8'd5,  8'hFF,  8'hF1,  "mult8_m3x5");
        run8(MD_DIV,  8'h80,  8'hFF, 8'h00,  8'h80,  "div8_ovf");
        run8(MD_DIV,  8'hF9,  8'h00, 8'hF9,  8'h01,  "div8_zero_neg");
        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            logic [7:0] a, b;
            o = 3'($urandom_range(0, 3));
            a = pick8();
            b = pick8();
            e = ref_fn(o, {24'b0, a}, {24'b0, b}, 8);
            run8(o, a, b, e[39:32], e[7:0], "rnd8");
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative multiply/divide unit that owns the HI/LO register pair of the MIPS datapath.
- Replaces the plain reg_hi/reg_lo registers.
- Executes MULT, MULTU, DIV, DIVU over WIDTH+1 cycles and MTHI/MTLO in one cycle.
- Exposes busy/ready so the CPU top-level can stall a later MFHI/MFLO or mul/div instruction until results are valid.

Parameters:
- WIDTH, 32, operand width and HI/LO register width; must be at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- clk_enable  input  1  when low, all state holds (same meaning as CPU clk_enable)
- op_valid  input  1  command present this cycle
- op  input  3  command code, see package
- rs_val  input  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO source)
- rt_val  input  WIDTH  operand B (divisor / multiplier)
- ready  output  1  combinational; high iff state==IDLE; command accepted when op_valid && ready at an enabled edge
- busy  output  1  registered; high in CALC and FIX
- done  output  1  registered one-cycle pulse after HI/LO update by a mul/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high.
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0.
  - Reset has priority over clk_enable and aborts any operation in progress; no partial result is written.
- clk_enable=0: no register changes (state, counter, hi, lo, done all hold). Commands are not accepted.
- States:
  - IDLE -> CALC on an accepted MULT/MULTU/DIV/DIVU.
  - CALC -> FIX when counter==WIDTH-1 at an enabled edge.
  - FIX -> IDLE at the next enabled edge.
- Accept edge E0:
  - latch the operand magnitudes (signed ops: two's-complement absolute value; unsigned: raw);
  - latch result-sign flags;
  - counter=0.
- CALC: one radix-2 step per enabled edge, WIDTH steps total.
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract giving quotient and remainder.
- FIX edge (E_{WIDTH+1}):
  - apply the sign correction;
  - MULT: hi:lo = {hi,lo} of the product, negated in 2*WIDTH bits if the signs differ;
  - DIV/DIVU: lo=quotient, hi=remainder;
  - state=IDLE, done=1 for exactly one cycle.
- Signed divide rules:
  - quotient is negative iff operand signs differ;
  - remainder takes the sign of the dividend (truncating division).
- Overflow and divide-by-zero (no trap):
  - DIV of min-int by -1: lo=min-int (wraps), hi=0.
  - DIVU by zero: lo=all-ones, hi=rs_val.
  - DIV by zero: lo=all-ones if rs_val>=0, else 1; hi=rs_val.
- Timing:
  - busy is high for exactly WIDTH+1 enabled cycles after E0.
  - hi/lo hold their old values until the FIX edge, so MFHI/MFLO reads during busy return stale data.
  - The CPU must stall on busy.
- MTHI/MTLO accepted in IDLE: hi (or lo) <= rs_val at that edge; no busy, no done.
- Reserved op codes (6, 7) with op_valid: ignored, no state change.
- Commands with op_valid while busy: ignored (ready=0); the issuer must hold them.
- A new command may be accepted in the done cycle; done then still pulses only once.

Decomposition:
- Shared package muldiv_pkg holds:
  - the 3-bit op enum: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5;
  - the state enum {IDLE, CALC, FIX}.
- No sub-module. The multiply and divide steps share one 2*WIDTH shift register and one WIDTH+1 adder/subtractor inside muldiv_unit.

Test Plan:
- WIDTH=32, MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy high 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULT -1*-1 -> hi=0, lo=1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
- MTHI 0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0.
- MTLO issued while busy -> ignored.
- Final hi/lo equal the mul/div result only.
- Reset asserted at CALC step 10 -> next cycle state IDLE, hi=lo=0, busy=0, done=0, ready=1.
- clk_enable low for 5 cycles mid-CALC (WIDTH=32) -> busy lasts 33+5 cycles, results unchanged.
- Repeat with WIDTH=8 -> DIVU 200/7 gives lo=28, hi=4, busy high 9 cycles.
